// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte producers.
// Optional source-ID header per byte; watchdog aborts a transfer with no txdone.
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SEND_ID = 0,
  parameter int TIMEOUT_CYC = 200000,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 err,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 uart_start,
  output logic [7:0]           uart_txin,
  input  logic                 uart_txdone
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_ACK
  } state_e;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]  last_q, last_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       txin_q, txin_d;
  logic             hdr_q, hdr_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             txd_q, txd_d;

  logic             found;
  logic [ID_W-1:0]  win;
  logic [ID_W-1:0]  cand;
  logic [7:0]       pay;

  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(last_q) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign pay = req_data[{win, 3'b000} +: 8];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    data_d  = data_q;
    txin_d  = txin_q;
    hdr_d   = hdr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    txd_d   = uart_txdone;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d = S_START;
          grant_d = win;
          data_d  = pay;
          err_d   = 1'b0;
          hdr_d   = (SEND_ID != 0);
          txin_d  = (SEND_ID != 0) ? (8'hA0 | 8'(win)) : pay;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        cnt_d   = '0;
        // A txdone level left high by the previous byte must not count
        txd_d   = 1'b1;
      end
      S_WAIT: begin
        if (uart_txdone && !txd_q) begin
          if (hdr_q) begin
            hdr_d   = 1'b0;
            txin_d  = data_q;
            state_d = S_START;
          end else begin
            state_d = S_ACK;
          end
        end else if (TIMEOUT_CYC != 0) begin
          if (cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            state_d = S_ACK;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_ACK: begin
        last_d  = grant_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      last_q  <= LAST_RST;
      data_q  <= 8'h00;
      txin_q  <= 8'h00;
      hdr_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      txd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      data_q  <= data_d;
      txin_q  <= txin_d;
      hdr_q   <= hdr_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    ack = '0;
    if (state_q == S_ACK) ack[grant_q] = 1'b1;
  end

  assign err        = (state_q == S_ACK) && err_q;
  assign busy       = (state_q != S_IDLE);
  assign uart_start = (state_q == S_START);
  assign grant_id   = grant_q;
  assign uart_txin  = txin_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: scoreboard of expected UART bytes and acks.
// dut0: no header, 50-cycle watchdog; dut1: header enabled.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] req0 = '0, req1 = '0;
  logic [31:0] dat0 = '0, dat1 = '0;
  logic [3:0] ack0, ack1;
  logic err0, err1, busy0, busy1;
  logic [1:0] gid0, gid1;
  logic st0, st1;
  logic [7:0] tx0, tx1;
  logic txd0 = 1'b0, txd1 = 1'b0;

  int tests = 0;
  int fails = 0;
  bit auto0 = 0, auto1 = 0, chk_gap = 0;

  logic [7:0] eb0[$], eb1[$];
  int eg0[$], eg1[$], ea0[$], ea1[$];
  bit ee0[$], ee1[$];
  logic [7:0] mb0, mb1;
  int mg0, mg1, ma0, ma1;
  bit me0, me1;
  time st_t0 = 0, ack_t0 = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(4), .SEND_ID(0), .TIMEOUT_CYC(50)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req0), .req_data(dat0),
    .ack(ack0), .err(err0), .busy(busy0), .grant_id(gid0),
    .uart_start(st0), .uart_txin(tx0), .uart_txdone(txd0)
  );

  uart_tx_arbiter #(
    .NUM_REQ(4), .SEND_ID(1), .TIMEOUT_CYC(200000)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .req_data(dat1),
    .ack(ack1), .err(err1), .busy(busy1), .grant_id(gid1),
    .uart_start(st1), .uart_txin(tx1), .uart_txdone(txd1)
  );

  // UART models: one-cycle txdone pulse 3 cycles after each start
  initial forever begin
    @(negedge clk);
    if (auto0 && st0) begin
      txd0 = 1'b0;
      repeat (3) @(negedge clk);
      txd0 = 1'b1;
    end else txd0 = 1'b0;
  end

  initial forever begin
    @(negedge clk);
    if (auto1 && st1) begin
      txd1 = 1'b0;
      repeat (3) @(negedge clk);
      txd1 = 1'b1;
    end else txd1 = 1'b0;
  end

  // Scoreboard monitor for dut0
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (st0) begin
        tests++;
        if (eb0.size() == 0) begin
          fails++;
          $display("FAIL sb0_start unexpected txin=%h gid=%0d", tx0, gid0);
        end else begin
          mb0 = eb0.pop_front();
          mg0 = eg0.pop_front();
          if (tx0 !== mb0 || gid0 !== 2'(mg0)) begin
            fails++;
            $display("FAIL sb0_start txin=%h gid=%0d want txin=%h gid=%0d",
                     tx0, gid0, mb0, mg0);
          end
        end
        if (chk_gap) begin
          tests++;
          if ($time - ack_t0 != 20) begin
            fails++;
            $display("FAIL ack_to_start gap=%0t want 20", $time - ack_t0);
          end
        end
        st_t0 = $time;
      end
      if (ack0 != 0 || err0) begin
        tests++;
        if (ea0.size() == 0) begin
          fails++;
          $display("FAIL sb0_ack unexpected ack=%b err=%b", ack0, err0);
        end else begin
          ma0 = ea0.pop_front();
          me0 = ee0.pop_front();
          if (ack0 !== 4'(1 << ma0) || err0 !== me0) begin
            fails++;
            $display("FAIL sb0_ack ack=%b err=%b want ack=%b err=%b",
                     ack0, err0, 4'(1 << ma0), me0);
          end
        end
        ack_t0 = $time;
      end
    end
  end

  // Scoreboard monitor for dut1
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (st1) begin
        tests++;
        if (eb1.size() == 0) begin
          fails++;
          $display("FAIL sb1_start unexpected txin=%h gid=%0d", tx1, gid1);
        end else begin
          mb1 = eb1.pop_front();
          mg1 = eg1.pop_front();
          if (tx1 !== mb1 || gid1 !== 2'(mg1)) begin
            fails++;
            $display("FAIL sb1_start txin=%h gid=%0d want txin=%h gid=%0d",
                     tx1, gid1, mb1, mg1);
          end
        end
      end
      if (ack1 != 0 || err1) begin
        tests++;
        if (ea1.size() == 0) begin
          fails++;
          $display("FAIL sb1_ack unexpected ack=%b err=%b", ack1, err1);
        end else begin
          ma1 = ea1.pop_front();
          me1 = ee1.pop_front();
          if (ack1 !== 4'(1 << ma1) || err1 !== me1) begin
            fails++;
            $display("FAIL sb1_ack ack=%b err=%b want ack=%b err=%b",
                     ack1, err1, 4'(1 << ma1), me1);
          end
        end
      end
    end
  end

  task automatic push0(input logic [7:0] b, input int g);
    eb0.push_back(b);
    eg0.push_back(g);
  endtask

  task automatic wait_acks(input bit sel, input int n, input bit drop,
                           output int seen);
    int k;
    seen = 0;
    k = 0;
    while (seen < n && k < 2000) begin
      @(negedge clk);
      k++;
      if (!sel && ack0 != 0) begin
        seen++;
        if (drop) req0 = req0 & ~ack0;
      end
      if (sel && ack1 != 0) begin
        seen++;
        if (drop) req1 = req1 & ~ack1;
      end
    end
  endtask

  task automatic wait_start0(output bit ok);
    int k;
    ok = 0;
    k = 0;
    while (!ok && k < 2000) begin
      @(negedge clk);
      k++;
      if (st0) ok = 1;
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({ack0, err0, busy0, gid0, st0, tx0} !== 17'h0) begin
      fails++;
      $display("FAIL reset0 outs=%h want 0",
               {ack0, err0, busy0, gid0, st0, tx0});
    end
    tests++;
    if ({ack1, err1, busy1, gid1, st1, tx1} !== 17'h0) begin
      fails++;
      $display("FAIL reset1 outs=%h want 0",
               {ack1, err1, busy1, gid1, st1, tx1});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    bit ok;
    int seen;
    auto0 = 1;
    dat0 = 32'h005A_0000;
    push0(8'h5A, 2);
    ea0.push_back(2); ee0.push_back(0);
    req0 = 4'b0100;
    wait_start0(ok);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL single_start seen=0 want 1");
    end
    @(negedge clk);
    tests++;
    if (st0 !== 1'b0 || busy0 !== 1'b1 || tx0 !== 8'h5A) begin
      fails++;
      $display("FAIL single_strobe start=%b busy=%b txin=%h want 0 1 5a",
               st0, busy0, tx0);
    end
    wait_acks(0, 1, 1, seen);
    tests++;
    if (seen != 1) begin
      fails++;
      $display("FAIL single_ack seen=%0d want 1", seen);
    end
    @(negedge clk);
    tests++;
    if (busy0 !== 1'b0 || ack0 !== 4'b0) begin
      fails++;
      $display("FAIL single_idle busy=%b ack=%b want 0 0", busy0, ack0);
    end
  endtask

  task automatic test_simultaneous();
    int seen;
    pulse_reset();
    auto0 = 1;
    dat0 = 32'h3300_1100;
    push0(8'h11, 1); push0(8'h33, 3);
    ea0.push_back(1); ee0.push_back(0);
    ea0.push_back(3); ee0.push_back(0);
    req0 = 4'b1010;
    wait_acks(0, 2, 1, seen);
    tests++;
    if (seen != 2 || eb0.size() != 0 || ea0.size() != 0) begin
      fails++;
      $display("FAIL simul acks=%0d left=%0d want 2 0",
               seen, eb0.size() + ea0.size());
    end
  endtask

  task automatic test_rotation();
    bit ok;
    int seen;
    int order[6] = '{0, 1, 2, 3, 0, 1};
    pulse_reset();
    auto0 = 1;
    dat0 = 32'h4342_4140;
    foreach (order[i]) begin
      push0(8'h40 + 8'(order[i]), order[i]);
      ea0.push_back(order[i]);
      ee0.push_back(0);
    end
    req0 = 4'hF;
    wait_start0(ok);
    @(negedge clk);
    chk_gap = 1;
    wait_acks(0, 6, 0, seen);
    req0 = 4'h0;
    chk_gap = 0;
    repeat (10) @(negedge clk);
    tests++;
    if (!ok || seen != 6 || eb0.size() != 0 || busy0 !== 1'b0) begin
      fails++;
      $display("FAIL rotation acks=%0d left=%0d busy=%b want 6 0 0",
               seen, eb0.size(), busy0);
    end
  endtask

  task automatic test_header();
    int seen;
    auto1 = 1;
    dat1 = 32'hC400_0000;
    eb1.push_back(8'hA3); eg1.push_back(3);
    eb1.push_back(8'hC4); eg1.push_back(3);
    ea1.push_back(3); ee1.push_back(0);
    req1 = 4'b1000;
    wait_acks(1, 1, 1, seen);
    tests++;
    if (seen != 1 || eb1.size() != 0) begin
      fails++;
      $display("FAIL header acks=%0d bytes_left=%0d want 1 0",
               seen, eb1.size());
    end
    @(negedge clk);
    tests++;
    if (busy1 !== 1'b0) begin
      fails++;
      $display("FAIL header_idle busy=%b want 0", busy1);
    end
  endtask

  task automatic test_timeout();
    int seen;
    time dt;
    pulse_reset();
    auto0 = 0;
    dat0 = 32'h0000_8877;
    push0(8'h77, 0); push0(8'h88, 1);
    ea0.push_back(0); ee0.push_back(1);
    ea0.push_back(1); ee0.push_back(0);
    req0 = 4'b0011;
    wait_acks(0, 1, 1, seen);
    dt = $time - st_t0;
    tests++;
    if (seen != 1 || dt != 510) begin
      fails++;
      $display("FAIL timeout acks=%0d start_to_ack=%0t want 1 510", seen, dt);
    end
    auto0 = 1;
    wait_acks(0, 1, 1, seen);
    tests++;
    if (seen != 1 || eb0.size() != 0 || ea0.size() != 0) begin
      fails++;
      $display("FAIL timeout_next acks=%0d left=%0d want 1 0",
               seen, eb0.size() + ea0.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int seen;
    pulse_reset();
    auto0 = 1;
    dat0 = 32'h0000_8877;
    push0(8'h77, 0);
    ea0.push_back(0); ee0.push_back(0);
    req0 = 4'b0001;
    wait_acks(0, 1, 1, seen);
    auto0 = 0;
    push0(8'h88, 1);
    req0 = 4'b0011;
    wait_start0(ok);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (!ok || seen != 1 ||
        {ack0, err0, busy0, gid0, st0, tx0} !== 17'h0) begin
      fails++;
      $display("FAIL reset_mid outs=%h ok=%b want 0 1",
               {ack0, err0, busy0, gid0, st0, tx0}, ok);
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    push0(8'h77, 0); push0(8'h88, 1);
    ea0.push_back(0); ee0.push_back(0);
    ea0.push_back(1); ee0.push_back(0);
    auto0 = 1;
    wait_acks(0, 2, 1, seen);
    tests++;
    if (seen != 2 || eb0.size() != 0 || ea0.size() != 0) begin
      fails++;
      $display("FAIL reset_mid_after acks=%0d left=%0d want 2 0",
               seen, eb0.size() + ea0.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_rotation();
    test_header();
    test_timeout();
    test_reset_mid();
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
